ring_arbiter7: RTL and testbench

RING_ARBITER7 -- requirements
Module: ring_arbiter7

---
 rtl/ring_arbiter7.sv | 167 ++++++++++++++++
 tb/tb_ring_arbiter7.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ring_arbiter7.sv
// ring_arbiter7 -- seven-requester round-robin arbiter with a hold limit.
//
// A single resource is handed to one requester at a time. The winner is the
// first requesting bit found by scanning upward from the TOKEN position and
// wrapping from bit 6 to bit 0. A grant ends on DONE, when the owner drops
// its request, or after MAXHOLD consecutive grant cycles. After each release
// the token moves one place past the old owner, and there is always at least
// one idle cycle before the next grant.
//
// Parameters:
//   MAXHOLD  maximum consecutive cycles a grant may stay high (2..255)
// Ports:
//   CLK      rising-edge clock
//   RESET    synchronous active-high reset
//   REQ      per-requester request, bit i is requester i
//   DONE     owner releases the resource (ignored while idle)
//   GNT      registered one-hot grant, zero when idle
//   OWNER    binary index of the granted requester, zero when idle
//   BUSY     high while a grant is active
//   TIMEOUT  one-cycle pulse after a release forced only by the hold limit
//   TOKEN    registered one-hot round-robin priority pointer
module ring_arbiter7 #(
  parameter int MAXHOLD = 15
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [6:0] REQ,
  input  logic       DONE,
  output logic [6:0] GNT,
  output logic [2:0] OWNER,
  output logic       BUSY,
  output logic       TIMEOUT,
  output logic [6:0] TOKEN
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Declaration initialisers give the same power-up values as reset.
  state_t     state_q   = IDLE;
  logic [6:0] gnt_q     = 7'b0000000;
  logic [2:0] owner_q   = 3'd0;
  logic [6:0] token_q   = 7'b0000001;
  logic [7:0] hold_q    = 8'd0;
  logic       timeout_q = 1'b0;

  state_t     state_d;
  logic [6:0] gnt_d;
  logic [2:0] owner_d;
  logic [6:0] token_d;
  logic [7:0] hold_d;
  logic       timeout_d;

  logic [2:0] tok_idx;
  logic [6:0] req_rot;
  logic [2:0] first_off;
  logic [3:0] win_sum;
  logic [2:0] win_idx;
  logic [6:0] win_onehot;
  logic       owner_req;
  logic       hold_hit;
  logic       rel_now;

  // Binary position of the one-hot token.
  always_comb begin
    tok_idx = 3'd0;
    case (token_q)
      7'b0000001: tok_idx = 3'd0;
      7'b0000010: tok_idx = 3'd1;
      7'b0000100: tok_idx = 3'd2;
      7'b0001000: tok_idx = 3'd3;
      7'b0010000: tok_idx = 3'd4;
      7'b0100000: tok_idx = 3'd5;
      7'b1000000: tok_idx = 3'd6;
      default:    tok_idx = 3'd0;
    endcase
  end

  // Rotate REQ so the token position lands on bit 0; the lowest set bit of
  // the rotated vector is then the distance from the token to the winner.
  always_comb begin
    req_rot   = (REQ >> tok_idx) | (REQ << (3'd7 - tok_idx));
    first_off = 3'd0;
    if (req_rot[0])      first_off = 3'd0;
    else if (req_rot[1]) first_off = 3'd1;
    else if (req_rot[2]) first_off = 3'd2;
    else if (req_rot[3]) first_off = 3'd3;
    else if (req_rot[4]) first_off = 3'd4;
    else if (req_rot[5]) first_off = 3'd5;
    else if (req_rot[6]) first_off = 3'd6;
    win_sum    = {1'b0, tok_idx} + {1'b0, first_off};
    win_idx    = (win_sum >= 4'd7) ? 3'(win_sum - 4'd7) : win_sum[2:0];
    win_onehot = 7'b0000001 << win_idx;
  end

  // Release is evaluated only in GRANT; TIMEOUT is reported solely when the
  // hold limit is the only reason for the release.
  always_comb begin
    owner_req = REQ[owner_q];
    hold_hit  = (hold_q == 8'(MAXHOLD));
    rel_now   = DONE | ~owner_req | hold_hit;

    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    token_d   = token_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (REQ != 7'b0000000) begin
          state_d = GRANT;
          gnt_d   = win_onehot;
          owner_d = win_idx;
          hold_d  = 8'd1;
        end
      end
      GRANT: begin
        if (rel_now) begin
          state_d   = IDLE;
          gnt_d     = 7'b0000000;
          owner_d   = 3'd0;
          token_d   = {gnt_q[5:0], gnt_q[6]};
          hold_d    = 8'd0;
          timeout_d = hold_hit & ~DONE & owner_req;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 7'b0000000;
        owner_d = 3'd0;
        hold_d  = 8'd0;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      gnt_q     <= 7'b0000000;
      owner_q   <= 3'd0;
      token_q   <= 7'b0000001;
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      token_q   <= token_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign GNT     = gnt_q;
  assign OWNER   = owner_q;
  assign BUSY    = (state_q == GRANT);
  assign TIMEOUT = timeout_q;
  assign TOKEN   = token_q;

endmodule

// File: tb/tb_ring_arbiter7.sv
// tb_ring_arbiter7 -- scoreboard bench for ring_arbiter7.
//
// The stimulus process drives inputs on the falling edge, steps an
// integer-level reference model of the arbiter and queues the outputs it
// expects after the next rising edge. A separate monitor pops one entry per
// rising edge and compares it with the DUT outputs.
module tb_ring_arbiter7;

  localparam int MH = 4;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [6:0] REQ;
  logic       DONE;
  logic [6:0] GNT;
  logic [2:0] OWNER;
  logic       BUSY;
  logic       TIMEOUT;
  logic [6:0] TOKEN;

  typedef struct packed {
    logic [6:0] gnt;
    logic [2:0] owner;
    logic       busy;
    logic       timeout;
    logic [6:0] token;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model: owner index (-1 when idle), token position, hold count.
  int m_owner = -1;
  int m_tpos  = 0;
  int m_hold  = 0;
  bit m_to    = 1'b0;

  ring_arbiter7 #(.MAXHOLD(MH)) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .REQ    (REQ),
    .DONE   (DONE),
    .GNT    (GNT),
    .OWNER  (OWNER),
    .BUSY   (BUSY),
    .TIMEOUT(TIMEOUT),
    .TOKEN  (TOKEN)
  );

  always #5 CLK = ~CLK;

  // Compare one value and record the outcome.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Advance the model by one rising edge using the arbitration rules directly.
  task automatic modelStep(input bit r, input logic [6:0] q, input bit d);
    bit drop;
    bit lim;
    int p;
    if (r) begin
      m_owner = -1;
      m_tpos  = 0;
      m_hold  = 0;
      m_to    = 1'b0;
    end else if (m_owner < 0) begin
      m_to = 1'b0;
      for (int k = 0; k < 7; k++) begin
        p = (m_tpos + k) % 7;
        if (m_owner < 0 && q[p[2:0]]) begin
          m_owner = p;
          m_hold  = 1;
        end
      end
    end else begin
      drop = !q[m_owner[2:0]];
      lim  = (m_hold == MH);
      if (d || drop || lim) begin
        m_to    = lim && !d && !drop;
        m_tpos  = (m_owner + 1) % 7;
        m_owner = -1;
        m_hold  = 0;
      end else begin
        m_hold++;
        m_to = 1'b0;
      end
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic applyStimulus(input bit r, input logic [6:0] q, input bit d);
    exp_t e;
    @(negedge CLK);
    RESET = r;
    REQ   = q;
    DONE  = d;
    modelStep(r, q, d);
    e.gnt     = (m_owner < 0) ? 7'd0 : 7'(1 << m_owner);
    e.owner   = (m_owner < 0) ? 3'd0 : 3'(m_owner);
    e.busy    = (m_owner >= 0);
    e.timeout = m_to;
    e.token   = 7'(1 << m_tpos);
    exp_q.push_back(e);
  endtask

  task automatic holdFor(input bit r, input logic [6:0] q, input bit d, input int n);
    for (int i = 0; i < n; i++) applyStimulus(r, q, d);
  endtask

  // Monitor: one expected entry per rising edge once stimulus has started.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("GNT",     32'(GNT),     32'(e.gnt));
        checkOutput("OWNER",   32'(OWNER),   32'(e.owner));
        checkOutput("BUSY",    32'(BUSY),    32'(e.busy));
        checkOutput("TIMEOUT", 32'(TIMEOUT), 32'(e.timeout));
        checkOutput("TOKEN",   32'(TOKEN),   32'(e.token));
      end
    end
  end

  initial begin
    logic [6:0] req_r;
    logic [6:0] flip;
    bit         d_r;
    bit         r_r;

    RESET = 1'b0;
    REQ   = 7'd0;
    DONE  = 1'b0;

    // Power-up values must already match the reset values.
    #1;
    checkOutput("init_GNT",   32'(GNT),   32'd0);
    checkOutput("init_BUSY",  32'(BUSY),  32'd0);
    checkOutput("init_TOKEN", 32'(TOKEN), 32'h01);

    $display("[TB] reset and alternating pair");
    holdFor(1'b1, 7'b0000000, 1'b0, 2);
    for (int g = 0; g < 3; g++) begin
      applyStimulus(1'b0, 7'b0000101, 1'b0);
      applyStimulus(1'b0, 7'b0000101, 1'b0);
      applyStimulus(1'b0, 7'b0000101, 1'b1);
    end

    $display("[TB] token wrap");
    holdFor(1'b1, 7'b0000000, 1'b0, 1);
    applyStimulus(1'b0, 7'b0010000, 1'b0);
    applyStimulus(1'b0, 7'b0010000, 1'b1);
    applyStimulus(1'b0, 7'b0000011, 1'b1);
    applyStimulus(1'b0, 7'b0000011, 1'b1);
    applyStimulus(1'b0, 7'b0000011, 1'b0);
    applyStimulus(1'b0, 7'b0000011, 1'b1);

    $display("[TB] hold limit timeout");
    holdFor(1'b1, 7'b0000000, 1'b0, 1);
    holdFor(1'b0, 7'b0001000, 1'b0, 14);

    $display("[TB] DONE on last allowed cycle");
    holdFor(1'b1, 7'b0000000, 1'b0, 1);
    holdFor(1'b0, 7'b0001000, 1'b0, 4);
    applyStimulus(1'b0, 7'b0001000, 1'b1);
    holdFor(1'b0, 7'b0000000, 1'b1, 2);

    $display("[TB] owner drops request");
    holdFor(1'b1, 7'b0000000, 1'b0, 1);
    holdFor(1'b0, 7'b1111111, 1'b0, 2);
    applyStimulus(1'b0, 7'b1111110, 1'b0);
    holdFor(1'b0, 7'b1111110, 1'b0, 3);

    $display("[TB] reset during grant");
    holdFor(1'b0, 7'b1111111, 1'b0, 2);
    applyStimulus(1'b1, 7'b1111111, 1'b0);
    holdFor(1'b0, 7'b1111111, 1'b0, 3);

    $display("[TB] randomized traffic");
    req_r = 7'($urandom);
    for (int c = 0; c < 600; c++) begin
      flip  = 7'($urandom) & 7'($urandom) & 7'($urandom);
      req_r = req_r ^ flip;
      d_r   = ($urandom_range(9) == 0);
      r_r   = ($urandom_range(59) == 0);
      applyStimulus(r_r, req_r, d_r);
    end

    // Let the monitor consume the last queued entries.
    repeat (3) @(posedge CLK);
    #2;
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
